data_mem_responder: RTL and testbench

//  Memory-side responder for the processor's data-memory port: word-addressed RAM with byte enables behind a

---
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 tb/tb_data_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM with byte enables behind valid/ready request and
// response channels, with a fixed number of wait states between accept and response.
module data_mem_responder #(
  parameter int unsigned AddrWidth  = 10,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned WaitStates = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [3:0]           req_be_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic                 resp_err_o
);

  localparam int unsigned WordAw   = AddrWidth - 2;
  localparam int unsigned Depth    = 2 ** WordAw;
  localparam logic [3:0]  WaitInit = 4'(WaitStates);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [3:0]             be_q;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [DataWidth-1:0]   mem [Depth];

  logic                   accept;
  logic                   commit;
  logic                   acc_we;
  logic [AddrWidth-1:0]   acc_addr;
  logic [DataWidth-1:0]   acc_wdata;
  logic [3:0]             acc_be;
  logic                   misaligned;
  logic [WordAw-1:0]      word_idx;

  assign req_ready_o  = (state_q == StIdle) && rst_ni;
  assign accept       = req_valid_i && req_ready_o;
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

  // With zero wait states the access commits on the accept edge, so use the live request.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = req_we_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      acc_be    = req_be_i;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign misaligned = (acc_addr[1:0] != 2'b00);
  assign word_idx   = acc_addr[AddrWidth-1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = WaitInit;
          if (WaitStates == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      StResp: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      if (misaligned) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end else if (acc_we) begin
        rdata_d = '0;
        err_d   = 1'b0;
      end else begin
        rdata_d = mem[word_idx];
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
    end
  end

  // RAM is never cleared; a reset edge suppresses any pending commit.
  always_ff @(posedge clk_i) begin
    if (rst_ni && commit && acc_we && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[word_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a 2-wait-state instance for the functional cases and a
// zero-wait-state instance for back-to-back throughput.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
  logic [9:0]  a_req_addr;
  logic [31:0] a_req_wdata, a_resp_rdata;
  logic [3:0]  a_req_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
  logic [9:0]  b_req_addr;
  logic [31:0] b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_be;

  data_mem_responder #(.AddrWidth(10), .DataWidth(32), .WaitStates(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
    .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_be_i(a_req_be),
    .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready),
    .resp_rdata_o(a_resp_rdata), .resp_err_o(a_resp_err)
  );

  data_mem_responder #(.AddrWidth(10), .DataWidth(32), .WaitStates(0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_be_i(b_req_be),
    .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
    .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] model_a [256];
  logic [31:0] model_b [256];
  logic [32:0] qa [$];
  logic [32:0] qb [$];
  logic [32:0] ea, eb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Returns {err, rdata} the responder should give, and applies stores to the model.
  function automatic logic [32:0] model_access(input bit sel, input logic we,
                                               input logic [9:0] addr, input logic [31:0] wdata,
                                               input logic [3:0] be);
    logic [31:0] w;
    if (addr[1:0] != 2'b00) return {1'b1, 32'h0};
    w = sel ? model_b[addr[9:2]] : model_a[addr[9:2]];
    if (!we) return {1'b0, w};
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
    if (sel) model_b[addr[9:2]] = w;
    else     model_a[addr[9:2]] = w;
    return 33'h0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && a_resp_valid && a_resp_ready) begin
      if (qa.size() == 0) check("a_unexpected_resp", 32'd1, 32'd0);
      else begin
        ea = qa.pop_front();
        check("a_rdata", a_resp_rdata, ea[31:0]);
        check("a_err", {31'b0, a_resp_err}, {31'b0, ea[32]});
      end
    end
    if (rst_n && b_resp_valid && b_resp_ready) begin
      if (qb.size() == 0) check("b_unexpected_resp", 32'd1, 32'd0);
      else begin
        eb = qb.pop_front();
        check("b_rdata", b_resp_rdata, eb[31:0]);
        check("b_err", {31'b0, b_resp_err}, {31'b0, eb[32]});
      end
    end
  end

  // Drive a request on instance A until accepted; scramble inputs right after the accept edge.
  task automatic a_accept(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int acc_cyc);
    int t = 0;
    a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be; a_req_valid = 1'b1;
    @(negedge clk);
    while (!a_req_ready && t < 50) begin @(negedge clk); t++; end
    if (!a_req_ready) check("a_accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    a_req_we    = 1'($urandom());
    a_req_addr  = 10'($urandom());
    a_req_wdata = $urandom();
    a_req_be    = 4'($urandom());
  endtask

  task automatic a_wait_resp(input int c0, input bit lat_chk);
    int t = 0;
    do begin @(negedge clk); t++; end while (!a_resp_valid && t < 50);
    if (!a_resp_valid) check("a_resp_timeout", 32'd0, 32'd1);
    if (lat_chk) check("a_latency", 32'(cyc - c0), 32'd3);
  endtask

  task automatic a_drain();
    int t = 0;
    while (qa.size() != 0 && t < 100) begin @(posedge clk); t++; end
    if (qa.size() != 0) check("a_drain_timeout", 32'(qa.size()), 32'd0);
    #1;
  endtask

  task automatic a_txn(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    int c0;
    qa.push_back(model_access(1'b0, we, addr, wdata, be));
    a_accept(we, addr, wdata, be, c0);
    a_wait_resp(c0, 1'b1);
    a_drain();
  endtask

  logic        op_we   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [9:0]  op_addr [7] = '{10'h000, 10'h004, 10'h008, 10'h000, 10'h004, 10'h008, 10'h005};
  logic [31:0] op_data [7] = '{32'h01234567, 32'h89ABCDEF, 32'h5A5A0F0F, 32'h0, 32'h0, 32'h0,
                               32'h0};

  initial begin
    int c0;
    int t;
    int last;
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
    a_resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    b_resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, a_req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, a_resp_valid}, 32'd0);
    check("rst_rdata", a_resp_rdata, 32'd0);
    check("rst_err", {31'b0, a_resp_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", {31'b0, a_req_ready}, 32'd1);
    @(posedge clk); #1;

    // Store then load
    a_txn(1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    a_txn(1'b0, 10'h010, 32'h0, 4'h0);

    // Byte enables
    a_txn(1'b1, 10'h020, 32'hFFFFFFFF, 4'hF);
    a_txn(1'b1, 10'h020, 32'h00000012, 4'b0001);
    a_txn(1'b0, 10'h020, 32'h0, 4'h0);
    a_txn(1'b1, 10'h020, 32'h00000000, 4'b0000);
    a_txn(1'b0, 10'h020, 32'h0, 4'hF);

    // Misaligned accesses leave memory untouched
    a_txn(1'b0, 10'h013, 32'h0, 4'h0);
    a_txn(1'b1, 10'h022, 32'h11223344, 4'hF);
    a_txn(1'b0, 10'h020, 32'h0, 4'h0);

    // Backpressure on a load
    a_resp_ready = 1'b0;
    qa.push_back(model_access(1'b0, 1'b0, 10'h010, 32'h0, 4'h0));
    a_accept(1'b0, 10'h010, 32'h0, 4'h0, c0);
    a_wait_resp(c0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, a_resp_valid}, 32'd1);
      check("bp_rdata", a_resp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", {31'b0, a_req_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    a_resp_ready = 1'b1;
    a_drain();
    @(negedge clk);
    check("bp_after_valid", {31'b0, a_resp_valid}, 32'd0);
    check("bp_after_ready", {31'b0, a_req_ready}, 32'd1);
    @(posedge clk); #1;

    // Reset while a store is waiting
    a_txn(1'b1, 10'h030, 32'h11111111, 4'hF);
    a_accept(1'b1, 10'h030, 32'hA5A5A5A5, 4'hF, c0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", {31'b0, a_resp_valid}, 32'd0);
    check("midrst_req_ready", {31'b0, a_req_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_resp_valid", {31'b0, a_resp_valid}, 32'd0);
    @(posedge clk); #1;
    a_txn(1'b0, 10'h030, 32'h0, 4'h0);

    // Zero-wait-state instance: back-to-back traffic
    last = 0;
    for (int i = 0; i < 7; i++) begin
      b_req_we = op_we[i]; b_req_addr = op_addr[i]; b_req_wdata = op_data[i]; b_req_be = 4'hF;
      b_req_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!b_req_ready && t < 20) begin @(negedge clk); t++; end
      if (!b_req_ready) check("b_accept_timeout", 32'd0, 32'd1);
      qb.push_back(model_access(1'b1, op_we[i], op_addr[i], op_data[i], 4'hF));
      if (i > 0) check("b_accept_spacing", 32'(cyc - last), 32'd2);
      last = cyc;
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      b_req_wdata = $urandom();
      @(negedge clk);
      check("b_latency", {31'b0, b_resp_valid}, 32'd1);
    end
    t = 0;
    while (qb.size() != 0 && t < 50) begin @(posedge clk); t++; end
    if (qb.size() != 0) check("b_drain_timeout", 32'(qb.size()), 32'd0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
